// File: rtl/vga_pkg.sv
// Shared raster constants and the coordinate type used by the timing generator,
// the movement controller and the pixel/sprite renderer.
package vga_pkg;

  localparam int H_DISP  = 800;
  localparam int H_FP    = 56;
  localparam int H_SYNC  = 120;
  localparam int H_BP    = 64;
  localparam int V_DISP  = 600;
  localparam int V_FP    = 37;
  localparam int V_SYNC  = 6;
  localparam int V_BP    = 23;

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_timing.sv
// One raster axis: a wrapping position counter plus display and sync region
// decode. The horizontal wrap drives the vertical instance's enable.
module vga_axis_timing
  import vga_pkg::*;
#(
  parameter int DISP = vga_pkg::H_DISP,
  parameter int FP   = vga_pkg::H_FP,
  parameter int SYNC = vga_pkg::H_SYNC,
  parameter int BP   = vga_pkg::H_BP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  output logic [10:0] o_cnt,
  output logic        o_wrap,
  output logic        o_disp,
  output logic        o_sync
);

  localparam int     TOTAL      = DISP + FP + SYNC + BP;
  localparam coord_t C_LAST     = coord_t'(TOTAL - 1);
  localparam coord_t C_DISP     = coord_t'(DISP);
  localparam coord_t C_SYNC_BEG = coord_t'(DISP + FP);
  // 12-bit end bound so a sync region ending exactly at 2048 still decodes.
  localparam logic [11:0] C_SYNC_END = 12'(DISP + FP + SYNC);

  coord_t r_cnt;
  logic   w_last;

  assign w_last = (r_cnt == C_LAST);
  assign o_wrap = i_en & w_last;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + coord_t'(1);
    end
  end

  assign o_disp = (r_cnt < C_DISP);
  assign o_sync = (r_cnt >= C_SYNC_BEG) && ({1'b0, r_cnt} < C_SYNC_END);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: coordinates, sync, blanking and SOF/EOF markers,
// all registered once from the counters so every output is mutually aligned.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_DISP   = vga_pkg::H_DISP,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_DISP   = vga_pkg::V_DISP,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] spotX,
  output logic [10:0] spotY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        SOF,
  output logic        EOF
);

  localparam int     H_TOTAL_L = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL_L = V_DISP + V_FP + V_SYNC + V_BP;
  localparam coord_t C_EOF_X   = coord_t'(H_DISP);
  localparam coord_t C_EOF_Y   = coord_t'(V_DISP - 1);

  if (H_TOTAL_L > 2048 || V_TOTAL_L > 2048) begin : g_bad_timing
    $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
  end

  coord_t w_hcnt, w_vcnt;
  logic   w_hwrap, w_vwrap;
  logic   w_hdisp, w_vdisp, w_hsync, w_vsync;
  logic   r_at_origin;

  vga_axis_timing #(.DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (1'b1),
    .o_cnt   (w_hcnt),
    .o_wrap  (w_hwrap),
    .o_disp  (w_hdisp),
    .o_sync  (w_hsync)
  );

  vga_axis_timing #(.DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_hwrap),
    .o_cnt   (w_vcnt),
    .o_wrap  (w_vwrap),
    .o_disp  (w_vdisp),
    .o_sync  (w_vsync)
  );

  // Counters sit at (0,0) only straight out of reset or the cycle after a
  // frame wrap, so this flag tracks the origin without a 22-bit compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_at_origin <= 1'b1;
    end else begin
      r_at_origin <= w_vwrap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spotX <= '0;
      spotY <= '0;
      blank <= 1'b0;
      hs    <= ~SYNC_POL;
      vs    <= ~SYNC_POL;
      SOF   <= 1'b0;
      EOF   <= 1'b0;
    end else begin
      spotX <= w_hcnt;
      spotY <= w_vcnt;
      blank <= w_hdisp & w_vdisp;
      hs    <= w_hsync ? SYNC_POL : ~SYNC_POL;
      vs    <= w_vsync ? SYNC_POL : ~SYNC_POL;
      SOF   <= r_at_origin;
      EOF   <= (w_hcnt == C_EOF_X) && (w_vcnt == C_EOF_Y);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, shrunk instances
// (both sync polarities) for frame-level behaviour, wrap and mid-frame reset.
module tb_vga_timing;

  localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_D = 6, SV_F = 2, SV_S = 2, SV_B = 1;
  localparam int SHT = SH_D + SH_F + SH_S + SH_B;   // 15
  localparam int SVT = SV_D + SV_F + SV_S + SV_B;   // 11
  localparam int SFRAME = SHT * SVT;                 // 165

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        blank, hs, vs, sof, eof;
  } out_t;

  typedef struct {
    int          cyc;
    logic [10:0] x, y;
    logic        blank, hs, vs, sof, eof;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] dX, dY, sX, sY, nX, nY;
  logic dB, dH, dV, dS, dE, sB, sH, sV, sS, sE, nB, nH, nV, nS, nE;
  out_t d_o, s_o, n_o;
  assign d_o = {dX, dY, dB, dH, dV, dS, dE};
  assign s_o = {sX, sY, sB, sH, sV, sS, sE};
  assign n_o = {nX, nY, nB, nH, nV, nS, nE};

  vga_timing u_dflt (
    .clk(clk), .reset_n(reset_n), .spotX(dX), .spotY(dY), .blank(dB),
    .hs(dH), .vs(dV), .SOF(dS), .EOF(dE)
  );

  vga_timing #(.H_DISP(SH_D), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
               .V_DISP(SV_D), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
               .SYNC_POL(1'b1)) u_small (
    .clk(clk), .reset_n(reset_n), .spotX(sX), .spotY(sY), .blank(sB),
    .hs(sH), .vs(sV), .SOF(sS), .EOF(sE)
  );

  vga_timing #(.H_DISP(SH_D), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
               .V_DISP(SV_D), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
               .SYNC_POL(1'b0)) u_neg (
    .clk(clk), .reset_n(reset_n), .spotX(nX), .spotY(nY), .blank(nB),
    .hs(nH), .vs(nV), .SOF(nS), .EOF(nE)
  );

  int errs = 0;
  int checks = 0;
  int t = 0;
  int phase = 0;
  out_t sb_d[$], sb_s[$], sb_n[$];
  vec_t vecs[12];
  int vi = 0;

  // Frame-level statistics on the shrunk positive-polarity instance.
  int sof_cnt = 0, eof_cnt = 0, last_sof = -1, last_eof = -1;
  int vs_cyc = 0, window_viol = 0, range_viol = 0;
  bit in_window = 0, prev_last = 0;
  // Line statistics on the full-size instance.
  int d_blank_cnt = 0, d_hs_cnt = 0, d_first_hs_x = -1;

  function automatic out_t model(input int tc, input int hd, input int hf, input int hsw,
                                 input int hb, input int vd, input int vf, input int vsw,
                                 input int vb, input logic pol);
    out_t o;
    int ht, vt, h, v;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    h = tc % ht;
    v = (tc / ht) % vt;
    o.x     = 11'(h);
    o.y     = 11'(v);
    o.blank = (h < hd) && (v < vd);
    o.hs    = (h >= hd + hf && h < hd + hf + hsw) ? pol : ~pol;
    o.vs    = (v >= vd + vf && v < vd + vf + vsw) ? pol : ~pol;
    o.sof   = (h == 0) && (v == 0);
    o.eof   = (h == hd) && (v == vd - 1);
    return o;
  endfunction

  function automatic out_t rst_val(input logic pol);
    out_t o;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b sof=%b eof=%b want x=%0d y=%0d blank=%b hs=%b vs=%b sof=%b eof=%b",
               name, t, act.x, act.y, act.blank, act.hs, act.vs, act.sof, act.eof,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.sof, exp.eof);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s t=%0d got %0d want %0d", name, t, act, exp);
    end
  endtask

  task automatic collect_stats();
    if (prev_last) begin
      check_int("wrap_xy", int'({sX, sY}), 0);
      check_int("wrap_sof", int'(sS), 1);
    end
    prev_last = (sX == 11'(SHT - 1)) && (sY == 11'(SVT - 1));
    if (sX >= 11'(SHT) || sY >= 11'(SVT)) range_viol++;
    if (sS) begin
      if (t < 2 * SFRAME) sof_cnt++;
      if (last_sof >= 0) check_int("sof_spacing", t - last_sof, SFRAME);
      last_sof = t;
      in_window = 0;
    end
    if (sE) begin
      if (t < 2 * SFRAME) eof_cnt++;
      check_int("eof_x", int'(sX), SH_D);
      check_int("eof_y", int'(sY), SV_D - 1);
      if (last_eof >= 0) check_int("eof_spacing", t - last_eof, SFRAME);
      last_eof = t;
      in_window = 1;
    end else if (in_window && sB) begin
      window_viol++;
    end
    if (sV && t < SFRAME) vs_cyc++;
    if (phase == 0 && t < 1040) begin
      if (dB) d_blank_cnt++;
      if (dH) begin
        d_hs_cnt++;
        if (d_first_hs_x < 0) d_first_hs_x = int'(dX);
      end
    end
  endtask

  // One clock: expectations queued at the edge, popped and compared mid-cycle.
  task automatic step();
    out_t ed, es, en;
    @(posedge clk);
    sb_d.push_back(model(t, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1));
    sb_s.push_back(model(t, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1));
    sb_n.push_back(model(t, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b0));
    @(negedge clk);
    ed = sb_d.pop_front();
    es = sb_s.pop_front();
    en = sb_n.pop_front();
    check_out("sb_dflt", d_o, ed);
    check_out("sb_small", s_o, es);
    check_out("sb_neg", n_o, en);
    if (phase == 0 && vi < 12 && vecs[vi].cyc == t) begin
      check_out($sformatf("vec%0d", vi), d_o,
                {vecs[vi].x, vecs[vi].y, vecs[vi].blank, vecs[vi].hs,
                 vecs[vi].vs, vecs[vi].sof, vecs[vi].eof});
      vi++;
    end
    collect_stats();
    t++;
  endtask

  initial begin
    vecs[0]  = '{0,    11'd0,    11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1,    11'd1,    11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{799,  11'd799,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{800,  11'd800,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{855,  11'd855,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{856,  11'd856,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{975,  11'd975,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{976,  11'd976,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1039, 11'd1039, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1040, 11'd0,    11'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1840, 11'd800,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2085, 11'd5,    11'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Held in reset: everything at reset values.
    repeat (3) @(negedge clk);
    check_out("rst_dflt", d_o, rst_val(1'b1));
    check_out("rst_small", s_o, rst_val(1'b1));
    check_out("rst_neg", n_o, rst_val(1'b0));
    reset_n = 1'b1;
    t = 0;

    repeat (2200) step();

    check_int("vec_applied", vi, 12);
    check_int("line_blank_cnt", d_blank_cnt, 800);
    check_int("line_hs_cnt", d_hs_cnt, 120);
    check_int("line_first_hs_x", d_first_hs_x, 856);
    check_int("two_frame_sof_cnt", sof_cnt, 2);
    check_int("two_frame_eof_cnt", eof_cnt, 2);
    check_int("vs_cycles", vs_cyc, SV_S * SHT);
    check_int("window_blank", window_viol, 0);
    check_int("coord_range", range_viol, 0);

    // Mid-frame reset on the shrunk instance at (5,3).
    begin
      int waited;
      waited = 0;
      while (!(sX == 11'd5 && sY == 11'd3) && waited < 2 * SFRAME) begin
        step();
        waited++;
      end
      check_int("reach_5_3", int'({sX, sY}), int'({11'd5, 11'd3}));
    end
    #1 reset_n = 1'b0;
    #1;
    check_out("midrst_dflt", d_o, rst_val(1'b1));
    check_out("midrst_small", s_o, rst_val(1'b1));
    check_out("midrst_neg", n_o, rst_val(1'b0));
    repeat (3) begin
      @(negedge clk);
      check_out("inrst_small", s_o, rst_val(1'b1));
      check_out("inrst_neg", n_o, rst_val(1'b0));
    end
    reset_n = 1'b1;
    phase = 1;
    t = 0;
    last_sof = -1;
    last_eof = -1;
    in_window = 0;
    prev_last = 0;
    step();
    check_int("post_rst_sof", int'(sS), 1);
    check_int("post_rst_xy", int'({sX, sY}), 0);
    check_int("post_rst_blank", int'(sB), 1);
    repeat (400) step();
    check_int("post_window_blank", window_viol, 0);
    check_int("post_coord_range", range_viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
